// File: rtl/nibble_packer_pkg.sv
// Shared constants and types for the nibble packer slice.
// Holds the fixed nibble width, parameter defaults and width helpers.
package nibble_packer_pkg;

  localparam int unsigned NIB_W             = 4;
  localparam int unsigned NIBS_PER_WORD_DEF = 4;
  localparam int unsigned FIFO_DEPTH_DEF    = 4;
  localparam int unsigned SEQ_MAX_DEF       = 7;

  localparam int unsigned WORD_W = NIB_W * NIBS_PER_WORD_DEF;
  localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH_DEF) + 1;

  typedef logic [WORD_W-1:0] word_t;

  // Packed word width for a given nibble count.
  function automatic int unsigned word_width(input int unsigned nibs);
    return NIB_W * nibs;
  endfunction

  // Level counter width able to represent 0..depth inclusive.
  function automatic int unsigned lvl_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/nibble_packer_fifo.sv
// packer_fifo: synchronous word FIFO with pointer+1-bit full/empty,
// a level output and a registered head word. The head register is
// refreshed from storage (or bypassed from the incoming word) so that
// it always shows the oldest entry; it holds its last value when empty.
module packer_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_b,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, wr_next, rd_next;
  logic [WIDTH-1:0] head_next;
  logic             empty, push_ok, pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);
  assign wr_next = wr_ptr + PW'(push_ok);
  assign rd_next = rd_ptr + PW'(pop_ok);

  assign out_valid = !empty;
  assign level     = wr_ptr - rd_ptr;

  // Select the word that will be at the head after this edge.
  always_comb begin
    head_next = head;
    if (wr_next != rd_next) begin
      if (push_ok && (rd_next == wr_ptr)) begin
        head_next = push_data;
      end else begin
        head_next = mem[rd_next[AW-1:0]];
      end
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk_b) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Pointer and head register update.
  always_ff @(posedge clk_b) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      head   <= '0;
    end else begin
      wr_ptr <= wr_next;
      rd_ptr <= rd_next;
      head   <= head_next;
    end
  end

endmodule

// File: rtl/nibble_packer.sv
// nibble_packer: packs received nibbles LSB-first into words, buffers
// them in packer_fifo and presents them on a valid/ready output.
// Optional sequence checker enabled by `define NIBBLE_PACKER_SEQ_CHECK_EN;
// without it seq_err is tied low and err_clr clears only overflow.
module nibble_packer
  import nibble_packer_pkg::*;
#(
  parameter int unsigned NIBS_PER_WORD = NIBS_PER_WORD_DEF,
  parameter int unsigned FIFO_DEPTH    = FIFO_DEPTH_DEF,
  parameter int unsigned SEQ_MAX       = SEQ_MAX_DEF
) (
  input  logic                                  clk_b,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  input  logic [NIB_W-1:0]                      in_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [word_width(NIBS_PER_WORD)-1:0]  out_data,
  output logic [lvl_width(FIFO_DEPTH)-1:0]      fifo_level,
  output logic                                  overflow,
  output logic                                  seq_err,
  input  logic                                  err_clr
);

  localparam int unsigned      PACK_W   = word_width(NIBS_PER_WORD);
  localparam int unsigned      CNT_W    = $clog2(NIBS_PER_WORD);
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBS_PER_WORD - 1);

  if ((NIBS_PER_WORD < 2) || ((NIBS_PER_WORD & (NIBS_PER_WORD - 1)) != 0)) begin : g_bad_nibs
    $error("nibble_packer: NIBS_PER_WORD must be a power of 2 and >= 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("nibble_packer: FIFO_DEPTH must be a power of 2 and >= 2");
  end
  if (SEQ_MAX >= (1 << NIB_W)) begin : g_bad_seq
    $error("nibble_packer: SEQ_MAX must fit in a nibble");
  end

  logic [CNT_W-1:0]  nib_cnt;
  logic [PACK_W-1:0] pack_q, pack_next;
  logic              word_done, pop_req, fifo_full, drop;

  assign word_done = in_valid && (nib_cnt == LAST_NIB);
  assign pop_req   = out_valid && out_ready;
  assign drop      = word_done && fifo_full && !pop_req;

  // Merge the incoming nibble into its slice; also forms the pushed word.
  always_comb begin
    pack_next = pack_q;
    if (in_valid) begin
      for (int unsigned i = 0; i < NIBS_PER_WORD; i++) begin
        if (nib_cnt == CNT_W'(i)) begin
          pack_next[i*NIB_W +: NIB_W] = in_data;
        end
      end
    end
  end

  // Slice counter and pack register; counter wraps even if the word drops.
  always_ff @(posedge clk_b) begin
    if (!rst_n) begin
      nib_cnt <= '0;
      pack_q  <= '0;
    end else if (in_valid) begin
      nib_cnt <= nib_cnt + 1'b1;
      pack_q  <= pack_next;
    end
  end

  packer_fifo #(
    .WIDTH (PACK_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_b     (clk_b),
    .rst_n     (rst_n),
    .push      (word_done),
    .push_data (pack_next),
    .pop       (pop_req),
    .out_valid (out_valid),
    .head      (out_data),
    .level     (fifo_level),
    .full      (fifo_full)
  );

  // Sticky overflow flag; a new drop wins over a simultaneous clear.
  always_ff @(posedge clk_b) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (err_clr) begin
      overflow <= 1'b0;
    end
  end

`ifdef NIBBLE_PACKER_SEQ_CHECK_EN
  localparam logic [NIB_W-1:0] SEQ_LAST = NIB_W'(SEQ_MAX);

  logic [NIB_W-1:0] expected, resync;
  logic             seq_miss;

  // Out-of-range values resync to 0 just like the wrap value.
  assign resync   = (in_data >= SEQ_LAST) ? '0 : in_data + 1'b1;
  assign seq_miss = in_valid && (in_data != expected);

  // Expected-value tracker; resyncs on every strobe so one gap flags once.
  always_ff @(posedge clk_b) begin
    if (!rst_n) begin
      expected <= '0;
    end else if (in_valid) begin
      expected <= resync;
    end
  end

  // Sticky sequence error flag; a new miss wins over a simultaneous clear.
  always_ff @(posedge clk_b) begin
    if (!rst_n) begin
      seq_err <= 1'b0;
    end else if (seq_miss) begin
      seq_err <= 1'b1;
    end else if (err_clr) begin
      seq_err <= 1'b0;
    end
  end
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_packer.sv
// Directed self-checking bench for nibble_packer (default parameters).
// Sequence-check expectations follow NIBBLE_PACKER_SEQ_CHECK_EN.
module tb_nibble_packer;
  import nibble_packer_pkg::*;

  logic             clk_b = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [NIB_W-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  word_t            out_data;
  logic [LVL_W-1:0] fifo_level;
  logic             overflow;
  logic             seq_err;
  logic             err_clr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_b = ~clk_b;

  nibble_packer #(
    .NIBS_PER_WORD (NIBS_PER_WORD_DEF),
    .FIFO_DEPTH    (FIFO_DEPTH_DEF),
    .SEQ_MAX       (SEQ_MAX_DEF)
  ) dut (
    .clk_b      (clk_b),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .seq_err    (seq_err),
    .err_clr    (err_clr)
  );

  // All tasks are entered and left at a falling edge.
  task automatic do_reset();
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk_b);
    @(negedge clk_b);
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [NIB_W-1:0] nib);
    in_valid = 1'b1;
    in_data  = nib;
    @(negedge clk_b);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input word_t w);
    for (int i = 0; i < 4; i++) send(w[i*4 +: 4]);
  endtask

  task automatic test_reset();
    @(negedge clk_b);
    do_reset();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h expected 0000", out_data); end
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    n_checks++; if (seq_err !== 1'b0) begin n_fail++; $display("FAIL reset_seq_err: got %b expected 0", seq_err); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send(4'h0); send(4'h1); send(4'h2);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_partial_valid: got %b expected 0", out_valid); end
    send(4'h3);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b expected 1", out_valid); end
    n_checks++; if (out_data !== 16'h3210) begin n_fail++; $display("FAIL basic_data: got %h expected 3210", out_data); end
    n_checks++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL basic_level1: got %0d expected 1", fifo_level); end
    @(negedge clk_b);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop: got %b expected 0", out_valid); end
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL basic_level0: got %0d expected 0", fifo_level); end
    n_checks++; if (out_data !== 16'h3210) begin n_fail++; $display("FAIL basic_data_hold: got %h expected 3210", out_data); end
    @(negedge clk_b);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_stays_low: got %b expected 0", out_valid); end
    n_checks++; if (seq_err !== 1'b0) begin n_fail++; $display("FAIL basic_seq_err: got %b expected 0", seq_err); end
    out_ready = 1'b0;
  endtask

  task automatic test_two_words();
    out_ready = 1'b0;
    send_word(16'h7654);
    send_word(16'h3210);
    n_checks++; if (fifo_level !== 3'd2) begin n_fail++; $display("FAIL two_level: got %0d expected 2", fifo_level); end
    n_checks++; if (out_data !== 16'h7654) begin n_fail++; $display("FAIL two_first: got %h expected 7654", out_data); end
    n_checks++; if (seq_err !== 1'b0) begin n_fail++; $display("FAIL two_wrap_seq_err: got %b expected 0", seq_err); end
    out_ready = 1'b1;
    @(negedge clk_b);
    n_checks++; if (out_data !== 16'h3210) begin n_fail++; $display("FAIL two_second: got %h expected 3210", out_data); end
    n_checks++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL two_level_after_pop: got %0d expected 1", fifo_level); end
    @(negedge clk_b);
    out_ready = 1'b0;
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL two_level_drained: got %0d expected 0", fifo_level); end
  endtask

  task automatic test_overflow();
    word_t exp_drain [4];
    exp_drain[0] = 16'h8765; exp_drain[1] = 16'hCBA9;
    exp_drain[2] = 16'h0FED; exp_drain[3] = 16'h2222;
    do_reset();
    send_word(16'h4321);
    send_word(16'h8765);
    send_word(16'hCBA9);
    send_word(16'h0FED);
    n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL ovf_level_full: got %0d expected 4", fifo_level); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_not_yet: got %b expected 0", overflow); end
    send_word(16'h1111);
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL ovf_level_after_drop: got %0d expected 4", fifo_level); end
    n_checks++; if (out_data !== 16'h4321) begin n_fail++; $display("FAIL ovf_head_unchanged: got %h expected 4321", out_data); end
    // Completing strobe coincides with a pop while full.
    send(4'h2); send(4'h2); send(4'h2);
    out_ready = 1'b1;
    send(4'h2);
    out_ready = 1'b0;
    n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL ovf_pushpop_level: got %0d expected 4", fifo_level); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (out_valid !== 1'b1 || out_data !== exp_drain[i]) begin n_fail++; $display("FAIL ovf_drain%0d: got valid=%b data=%h expected valid=1 data=%h", i, out_valid, out_data, exp_drain[i]); end
      out_ready = 1'b1;
      @(negedge clk_b);
      out_ready = 1'b0;
    end
    n_checks++; if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin n_fail++; $display("FAIL ovf_empty: got valid=%b level=%0d expected valid=0 level=0", out_valid, fifo_level); end
    n_checks++; if (out_data !== 16'h2222) begin n_fail++; $display("FAIL ovf_data_hold: got %h expected 2222", out_data); end
    err_clr = 1'b1;
    @(negedge clk_b);
    err_clr = 1'b0;
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b expected 0", overflow); end
  endtask

`ifdef NIBBLE_PACKER_SEQ_CHECK_EN
  task automatic test_seq();
    do_reset();
    send(4'h0); send(4'h1);
    n_checks++; if (seq_err !== 1'b0) begin n_fail++; $display("FAIL seq_clean: got %b expected 0", seq_err); end
    send(4'h3);
    n_checks++; if (seq_err !== 1'b1) begin n_fail++; $display("FAIL seq_gap: got %b expected 1", seq_err); end
    // Clear concurrent with nibble 4: only clears if 4 is not a new error.
    err_clr = 1'b1;
    send(4'h4);
    err_clr = 1'b0;
    n_checks++; if (seq_err !== 1'b0) begin n_fail++; $display("FAIL seq_resync_clr: got %b expected 0", seq_err); end
    n_checks++; if (out_data !== 16'h4310 || fifo_level !== 3'd1) begin n_fail++; $display("FAIL seq_word: got %h level=%0d expected 4310 level=1", out_data, fifo_level); end
    err_clr = 1'b1;
    send(4'h6);
    err_clr = 1'b0;
    n_checks++; if (seq_err !== 1'b1) begin n_fail++; $display("FAIL seq_set_wins: got %b expected 1", seq_err); end
    err_clr = 1'b1;
    @(negedge clk_b);
    err_clr = 1'b0;
    n_checks++; if (seq_err !== 1'b0) begin n_fail++; $display("FAIL seq_clr: got %b expected 0", seq_err); end
    send(4'h9);
    n_checks++; if (seq_err !== 1'b1) begin n_fail++; $display("FAIL seq_out_of_range: got %b expected 1", seq_err); end
    err_clr = 1'b1;
    send(4'h0);
    err_clr = 1'b0;
    n_checks++; if (seq_err !== 1'b0) begin n_fail++; $display("FAIL seq_range_resync: got %b expected 0", seq_err); end
  endtask
`else
  task automatic test_seq();
    do_reset();
    send(4'h0); send(4'h2); send(4'h5); send(4'h1);
    n_checks++; if (seq_err !== 1'b0) begin n_fail++; $display("FAIL noseq_err: got %b expected 0", seq_err); end
    n_checks++; if (out_data !== 16'h1520 || fifo_level !== 3'd1) begin n_fail++; $display("FAIL noseq_word: got %h level=%0d expected 1520 level=1", out_data, fifo_level); end
  endtask
`endif

  task automatic test_mid_word_reset();
    do_reset();
    send(4'h7); send(4'h7);
    do_reset();
    n_checks++; if (fifo_level !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_empty: got level=%0d valid=%b expected 0/0", fifo_level, out_valid); end
    send_word(16'h3210);
    n_checks++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL mid_reset_level: got %0d expected 1", fifo_level); end
    n_checks++; if (out_data !== 16'h3210) begin n_fail++; $display("FAIL mid_reset_word: got %h expected 3210", out_data); end
    n_checks++; if (seq_err !== 1'b0) begin n_fail++; $display("FAIL mid_reset_seq_err: got %b expected 0", seq_err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_two_words();
    test_overflow();
    test_seq();
    test_mid_word_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
